// File: rtl/pot_sampler.sv
// Round-robin sampler for an ADC128S-style SPI converter. Each channel costs a
// command frame (address) and a read frame (result); results land in a packed bus.
module pot_sampler #(
  parameter int NUM_CH   = 5,
  parameter int SCLK_DIV = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic [12*NUM_CH-1:0] pots,
  output logic                 pot_vld,
  output logic [2:0]           pot_ch,
  output logic                 round_done,
  output logic                 SS_n,
  output logic                 SCLK,
  output logic                 MOSI,
  input  logic                 MISO
);

  localparam int DW = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(SCLK_DIV / 2);
  localparam logic [DW-1:0] DIV_PRE  = DW'(SCLK_DIV / 2 - 1);
  localparam logic [2:0]    CH_LAST  = 3'(NUM_CH - 1);

  typedef enum logic [2:0] {IDLE, CMD, GAP1, RD, GAP2} state_t;

  state_t              state_q;
  logic [DW-1:0]       div_q, div_d;
  logic [3:0]          bit_q, bit_d;
  logic [2:0]          ch_q, ch_d;
  logic [11:0]         sh_q;
  logic [12*NUM_CH-1:0] pots_q;
  logic                vld_q, rdone_q;
  logic [2:0]          pch_q;
  logic                ss_q, sclk_q, mosi_q;
  logic [15:0]         cmd_word;
  logic                frame_last;

  always_comb begin
    cmd_word   = {2'b00, ch_q, 11'b0};
    frame_last = (div_q == DIV_LAST) && (bit_q == 4'd15);
    div_d      = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    bit_d      = (div_q == DIV_LAST) ? bit_q + 4'd1 : bit_q;
    ch_d       = (ch_q == CH_LAST) ? 3'd0 : ch_q + 3'd1;
  end

  // Outputs are registered alongside the state so SS_n/SCLK/MOSI describe
  // the cycle the FSM is in; every frame entry preloads the first MOSI bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      ch_q    <= '0;
      sh_q    <= '0;
      pots_q  <= '0;
      vld_q   <= 1'b0;
      rdone_q <= 1'b0;
      pch_q   <= '0;
      ss_q    <= 1'b1;
      sclk_q  <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      vld_q   <= 1'b0;
      rdone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ss_q   <= 1'b1;
          sclk_q <= 1'b1;
          mosi_q <= 1'b0;
          if (en) begin
            state_q <= CMD;
            div_q   <= '0;
            bit_q   <= '0;
            ss_q    <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= cmd_word[15];
          end
        end
        CMD, RD: begin
          // Only the last 12 bits shifted in survive; the ADC's leading
          // nibble and the whole command-frame response fall off the end.
          if (div_q == DIV_PRE) sh_q <= {sh_q[10:0], MISO};
          if (frame_last) begin
            state_q <= (state_q == CMD) ? GAP1 : GAP2;
            div_q   <= '0;
            ss_q    <= 1'b1;
            sclk_q  <= 1'b1;
            mosi_q  <= 1'b0;
          end else begin
            div_q  <= div_d;
            bit_q  <= bit_d;
            sclk_q <= (div_d >= DIV_HALF);
            mosi_q <= cmd_word[4'd15 - bit_d];
          end
        end
        GAP1: begin
          if (div_q == DIV_LAST) begin
            state_q <= RD;
            div_q   <= '0;
            bit_q   <= '0;
            ss_q    <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= cmd_word[15];
          end else begin
            div_q <= div_d;
          end
        end
        GAP2: begin
          if (div_q == '0) begin
            for (int k = 0; k < NUM_CH; k++)
              if (ch_q == 3'(k)) pots_q[12*k +: 12] <= sh_q;
            vld_q   <= 1'b1;
            pch_q   <= ch_q;
            rdone_q <= (ch_q == CH_LAST);
            ch_q    <= ch_d;
          end
          // ch_q has already advanced here, so cmd_word addresses the next slot.
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            bit_q <= '0;
            if (en) begin
              state_q <= CMD;
              ss_q    <= 1'b0;
              sclk_q  <= 1'b0;
              mosi_q  <= cmd_word[15];
            end else begin
              state_q <= IDLE;
            end
          end else begin
            div_q <= div_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pots       = pots_q;
  assign pot_vld    = vld_q;
  assign pot_ch     = pch_q;
  assign round_done = rdone_q;
  assign SS_n       = ss_q;
  assign SCLK       = sclk_q;
  assign MOSI       = mosi_q;

endmodule
